// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART with TXD/RXD/CON bus registers and a level IRQ.
// Independent RX and TX state machines run at a fixed BAUD_DIV clocks per bit.
`default_nettype none

module uart_ctrl #(
    parameter int          BAUD_DIV = 5208,
    parameter logic [31:0] BASE     = 32'h40000018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);

    localparam int          CW         = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] c_cnt_half = CW'(BAUD_DIV / 2 - 1);
    localparam logic [31:0] c_addr_txd = BASE;
    localparam logic [31:0] c_addr_rxd = BASE + 32'd4;
    localparam logic [31:0] c_addr_con = BASE + 32'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
    assign w_wr_txd = wr && (addr == c_addr_txd);
    assign w_wr_con = wr && (addr == c_addr_con);
    assign w_rd_rxd = rd && (addr == c_addr_rxd);
    assign w_rd_con = rd && (addr == c_addr_con);

    logic w_unused;
    assign w_unused = ^wdata[31:8];

    // ---------------- RX path ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    state_t        r_rx_state, w_rx_state_nx;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]    r_rx_bit, w_rx_bit_nx;
    logic [7:0]    r_rx_shift, w_rx_shift_nx;
    logic          w_rx_fall, w_rx_good, w_rx_bad;

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            // Synchronizer resets to the idle level so release never fakes a start edge
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= UART_RX;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + CW'(1);
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_good     = 1'b0;
        w_rx_bad      = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nx = '0;
                if (w_rx_fall) begin
                    w_rx_state_nx = S_START;
                    w_rx_bit_nx   = '0;
                end
            end
            S_START: begin
                if (r_rx_cnt == c_cnt_half) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = r_rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == c_cnt_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_bit_nx   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7)
                        w_rx_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == c_cnt_last) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = S_IDLE;
                    w_rx_good     = r_rx_s2;
                    w_rx_bad      = ~r_rx_s2;
                end
            end
            default: w_rx_state_nx = S_IDLE;
        endcase
    end

    // ---------------- TX path ----------------
    state_t        r_tx_state, w_tx_state_nx;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]    r_tx_bit, w_tx_bit_nx;
    logic [7:0]    r_tx_shift, w_tx_shift_nx;
    logic          r_tx_out, w_tx_out_nx;
    logic          w_tx_end, w_tx_busy;

    assign w_tx_busy = (r_tx_state != S_IDLE);
    assign UART_TX   = r_tx_out;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_out   <= w_tx_out_nx;
        end
    end

    // The line value for the next bit is registered at each bit boundary.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + CW'(1);
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_tx_out_nx   = r_tx_out;
        w_tx_end      = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nx = '0;
                w_tx_out_nx = 1'b1;
                if (w_wr_txd) begin
                    w_tx_state_nx = S_START;
                    w_tx_shift_nx = wdata[7:0];
                    w_tx_bit_nx   = '0;
                    w_tx_out_nx   = 1'b0;
                end
            end
            S_START: begin
                if (r_tx_cnt == c_cnt_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = S_DATA;
                    w_tx_out_nx   = r_tx_shift[0];
                    w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                end
            end
            S_DATA: begin
                if (r_tx_cnt == c_cnt_last) begin
                    w_tx_cnt_nx = '0;
                    w_tx_bit_nx = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = S_STOP;
                        w_tx_out_nx   = 1'b1;
                    end else begin
                        w_tx_out_nx   = r_tx_shift[0];
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (r_tx_cnt == c_cnt_last) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = S_IDLE;
                    w_tx_out_nx   = 1'b1;
                    w_tx_end      = 1'b1;
                end
            end
            default: w_tx_state_nx = S_IDLE;
        endcase
    end

    // ---------------- Registers and flags ----------------
    logic       r_tx_ie, r_rx_ie, r_tx_done, r_rx_valid, r_frame_err, r_overrun;
    logic [7:0] r_rxd;

    // Set terms are tested first so a same-cycle set beats a read clear.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_tx_ie     <= 1'b0;
            r_rx_ie     <= 1'b0;
            r_tx_done   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rxd       <= '0;
        end else begin
            if (w_wr_con) begin
                r_tx_ie <= wdata[0];
                r_rx_ie <= wdata[1];
            end
            if (w_rx_good)
                r_rxd <= r_rx_shift;
            r_rx_valid  <= w_rx_good ? 1'b1 : (w_rd_rxd ? 1'b0 : r_rx_valid);
            r_overrun   <= (w_rx_good && r_rx_valid) ? 1'b1 : (w_rd_con ? 1'b0 : r_overrun);
            r_frame_err <= w_rx_bad ? 1'b1 : (w_rd_con ? 1'b0 : r_frame_err);
            r_tx_done   <= w_tx_end ? 1'b1 : (w_rd_con ? 1'b0 : r_tx_done);
        end
    end

    always_comb begin
        rdata = '0;
        if (w_rd_rxd)
            rdata = {24'd0, r_rxd};
        else if (w_rd_con)
            rdata = {25'd0, r_overrun, r_frame_err, w_tx_busy, r_rx_valid,
                     r_tx_done, r_rx_ie, r_tx_ie};
    end

    assign irq = (r_tx_done & r_tx_ie) | (r_rx_valid & r_rx_ie);

endmodule

`default_nettype wire

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl at a short baud divisor.
`default_nettype none

module tb_uart_ctrl;

    localparam int          B      = 16;
    localparam int          CLK_NS = 20;
    localparam int          BIT_NS = B * CLK_NS;
    localparam logic [31:0] A_TXD  = 32'h40000018;
    localparam logic [31:0] A_RXD  = 32'h4000001C;
    localparam logic [31:0] A_CON  = 32'h40000020;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] rdata;
    logic        UART_RX = 1'b1;
    logic        UART_TX;
    logic        irq;

    int vectors    = 0;
    int miscompares = 0;

    uart_ctrl #(.BAUD_DIV(B), .BASE(A_TXD)) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX),
        .irq     (irq)
    );

    always #(CLK_NS / 2) sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge sysclk);
        rd   = 1'b1;
        addr = a;
        #1 d = rdata;
        @(posedge sysclk);
        #1;
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge sysclk);
        #1;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge sysclk);
        UART_RX = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            #(BIT_NS);
        end
        UART_RX = stop;
        #(BIT_NS);
        UART_RX = 1'b1;
        #(BIT_NS);
    endtask

    logic [31:0] d;
    logic [9:0]  tx_pat;

    initial begin
        // Reset held low
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_tx", {31'd0, UART_TX}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus_rd(A_CON, d);
        check("rst_con", d, 32'd0);

        reset = 1'b1;
        repeat (50) @(posedge sysclk);
        #1;
        check("idle_tx", {31'd0, UART_TX}, 32'd1);
        check("idle_irq", {31'd0, irq}, 32'd0);
        bus_rd(A_CON, d);
        check("idle_con", d, 32'd0);
        bus_rd(A_RXD, d);
        check("idle_rxd", d, 32'd0);

        // Single RX byte
        send_frame(8'h18, 1'b1);
        bus_rd(A_CON, d);
        check("rx18_con", d, 32'h08);
        bus_rd(A_RXD, d);
        check("rx18_rxd", d, 32'h18);
        bus_rd(A_CON, d);
        check("rx18_con_clr", d, 32'h00);

        // Overrun with rx_ie
        bus_wr(A_CON, 32'h2);
        send_frame(8'h18, 1'b1);
        check("ov_irq1", {31'd0, irq}, 32'd1);
        send_frame(8'h78, 1'b1);
        bus_rd(A_CON, d);
        check("ov_con", d, 32'h4A);
        bus_rd(A_RXD, d);
        check("ov_rxd", d, 32'h78);
        bus_rd(A_CON, d);
        check("ov_con_clr", d, 32'h02);
        check("ov_irq0", {31'd0, irq}, 32'd0);

        // Framing error keeps prior byte and rx_valid
        send_frame(8'h3C, 1'b1);
        send_frame(8'h55, 1'b0);
        bus_rd(A_CON, d);
        check("fe_con", d, 32'h2A);
        bus_rd(A_CON, d);
        check("fe_con_clr", d, 32'h0A);
        bus_rd(A_RXD, d);
        check("fe_rxd", d, 32'h3C);

        // Glitch shorter than half a bit
        @(negedge sysclk);
        UART_RX = 1'b0;
        #(3 * CLK_NS);
        UART_RX = 1'b1;
        repeat (20 * B) @(posedge sysclk);
        bus_rd(A_CON, d);
        check("gl_con", d, 32'h02);
        bus_rd(A_RXD, d);
        check("gl_rxd", d, 32'h3C);

        // TX 0xA5 with tx_ie; second write while busy is ignored
        bus_wr(A_CON, 32'h1);
        bus_wr(A_TXD, 32'hA5);
        bus_wr(A_TXD, 32'hFF);
        repeat (B / 2 - 1) @(posedge sysclk);
        #1;
        tx_pat = 10'b11_1010_0101 << 1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), {31'd0, UART_TX}, {31'd0, tx_pat[k]});
            if (k == 0)
                check("tx_irq_busy", {31'd0, irq}, 32'd0);
            repeat (B) @(posedge sysclk);
            #1;
        end
        check("tx_irq_done", {31'd0, irq}, 32'd1);
        check("tx_idle", {31'd0, UART_TX}, 32'd1);
        bus_rd(A_CON, d);
        check("tx_con", d, 32'h05);
        check("tx_irq_clr", {31'd0, irq}, 32'd0);
        bus_rd(A_CON, d);
        check("tx_con_clr", d, 32'h01);

        // Reset mid-TX and mid-RX
        bus_wr(A_TXD, 32'h00);
        UART_RX = 1'b0;
        repeat (3 * B) @(posedge sysclk);
        #1;
        check("mid_tx_low", {31'd0, UART_TX}, 32'd0);
        @(negedge sysclk);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, UART_TX}, 32'd1);
        UART_RX = 1'b1;
        bus_rd(A_CON, d);
        check("mid_rst_con", d, 32'd0);
        repeat (3) @(posedge sysclk);
        reset = 1'b1;
        repeat (20 * B) @(posedge sysclk);
        bus_rd(A_CON, d);
        check("post_con", d, 32'd0);
        bus_rd(A_RXD, d);
        check("post_rxd", d, 32'd0);
        send_frame(8'h5A, 1'b1);
        bus_rd(A_CON, d);
        check("post_rx_con", d, 32'h08);
        bus_rd(A_RXD, d);
        check("post_rx_rxd", d, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller between the pipeline CPU's peripheral bus and the board's `UART_RX`/`UART_TX` pins. It sequences 8N1 frames at a fixed baud rate through independent receive and transmit state machines. Received bytes and transmit requests pass through three bus registers, which also carry status flags. An interrupt request line goes to the CPU's exception logic.

## Interface
- `BAUD_DIV`, default 5208: sysclk cycles per bit (50 MHz / 9600 baud).
- `BASE`, default 32'h40000018: address of TXD. RXD is at BASE+4, CON at BASE+8.

Ports:
- `sysclk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd`  in  1  bus read strobe.
- `wr`  in  1  bus write strobe.
- `addr`  in  32  bus byte address.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  bus read data (combinational).
- `UART_RX`  in  1  serial input, asynchronous to sysclk, idle high.
- `UART_TX`  out  1  serial output, idle high.
- `irq`  out  1  interrupt request, level-sensitive.

## Operation
- Registers:
  - TXD, write-only. A write loads `wdata[7:0]` and starts a frame if TX is idle. A write while TX is busy is ignored.
  - RXD, read-only. Bits [7:0] hold the last good byte; upper bits read 0. A read clears `rx_valid`.
  - CON, read/write. Bit 0 is `tx_ie` and bit 1 is `rx_ie`; both are R/W.
  - CON read-only flags: bit 2 `tx_done`, bit 3 `rx_valid`, bit 4 `tx_busy`, bit 5 `frame_err`, bit 6 `overrun`. Bits 31:7 read 0.
  - Reading CON clears `tx_done`, `frame_err` and `overrun`. Writing CON changes only bits 1:0.
- `rdata` equals the addressed register when `rd`=1 and `addr` matches. Otherwise `rdata`=0.
- Read side effects (the clears) take effect on the sysclk edge where `rd`=1.
- If a flag is set and cleared in the same cycle, set wins.
- `irq` = (`tx_done` & `tx_ie`) | (`rx_valid` & `rx_ie`).
- RX path: `UART_RX` passes through a 2-flop synchronizer. An edge detector works on the synchronized signal.
- RX FSM states are IDLE, START, DATA and STOP:
  - IDLE: a 1→0 transition of the synchronized input moves to START, with the bit counter cleared.
  - START: wait BAUD_DIV/2 cycles, then sample the line. A low sample goes to DATA. A high sample is a glitch and returns to IDLE with no flag change.
  - DATA: sample every BAUD_DIV cycles and shift in LSB first. After 8 bits go to STOP.
  - STOP: sample after BAUD_DIV cycles. A high sample latches the byte into RXD and sets `rx_valid`; if `rx_valid` was already 1, `overrun` is also set and the old byte is overwritten. A low sample discards the byte and sets `frame_err`. Either way, return to IDLE.
- TX FSM states are IDLE, START, DATA and STOP. Each state holds its bit for exactly BAUD_DIV cycles.
  - Sequence: start bit 0, then data LSB first, then stop bit 1, then back to IDLE.
  - `tx_busy`=1 whenever the state is not IDLE.
  - `tx_done` is set on the cycle the stop-bit period ends.
- Reset mid-frame aborts both FSMs immediately. `UART_TX` returns high and the partial RX byte is lost.

## Timing
- Reset values:
  - `UART_TX`=1 and `irq`=0.
  - All flags are 0, `tx_ie`=`rx_ie`=0 and RXD=0.
  - Both FSMs are in IDLE and all counters are 0.
- TX: on the write edge, `UART_TX` falls, registered, and is visible in the following cycle.
- The TX frame lasts 10×BAUD_DIV cycles. `tx_busy` drops and `tx_done` rises in the same cycle.
- RX: `rx_valid` rises 9.5×BAUD_DIV + 2 (±1) cycles after the falling edge of the start bit on the pin.
- Bit sampling occurs at mid-bit, within ±1 cycle.
- Counter widths are ceil(log2(BAUD_DIV)) bits. Bit counters are 3 bits and wrap from 7 into the stop state.
- A TXD write in the same cycle that TX returns to IDLE is ignored. Software must see `tx_busy`=0 first.

## Test plan
- Reset: with `reset` low, expect `UART_TX`=1, `irq`=0 and CON reads 0. After release, check that nothing changes while the line is idle.
- RX 0x18 at BAUD_DIV=5208 with 20 ns sysclk: drive 10 bits of 104166 ns each (0,0,0,0,1,1,0,0,0,1). Expect RXD=0x18 and CON bit 3=1. Read RXD, then expect bit 3=0.
- Back-to-back RX without reading: 0x18 then 0x78. Expect RXD=0x78 with `overrun`=1. Reading CON clears `overrun`.
- Framing error and glitch:
  - Stop bit driven 0: expect `frame_err`=1 and `rx_valid` unchanged.
  - 1000 ns low pulse: expect no state change.
- TX 0xA5 with `tx_ie`=1: check `UART_TX` against the pattern 0,1,0,1,0,0,1,0,1,1, with each bit lasting BAUD_DIV cycles. At the end, `irq`=1.
  - A second TXD write while busy is ignored.
  - A CON read clears `irq`.
- Reset asserted mid-TX and mid-RX: `UART_TX` returns to 1 immediately, no byte is latched, and a following RX completes normally.
